acc_seq_ctrl: RTL and testbench

Instruction sequencer for the 8-bit accumulator datapath. Fetches 8-bit instructions from a synchronous single-port memory, decodes them, and drives the memory address/read/write strobes, the ALU opcode and the accumulator `update` strobe. It owns the program counter and instruction register. It sits between program/data memory and the ALU+accumulator pair, as the only source of `update`.

---
 rtl/acc_seq_ctrl_if.sv | 23 ++
 rtl/acc_seq_ctrl.sv | 114 +++++++++++
 tb/tb_acc_seq_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_seq_ctrl_if.sv
// Memory and datapath bus between the accumulator sequencer and its environment.
// The master side is the sequencer; the slave side is the memory + ALU/accumulator.
interface acc_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_rdata;
  logic [2:0]        alu_op;
  logic              acc_update;
  logic              acc_zero;

  modport master (
    output mem_addr, mem_rd, mem_wr, alu_op, acc_update,
    input  mem_rdata, acc_zero
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, alu_op, acc_update,
    output mem_rdata, acc_zero
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Instruction sequencer for the 8-bit accumulator datapath: fetch/decode/execute
// FSM owning the PC and IR. Outputs depend on state and IR only.
module acc_seq_ctrl #(
  parameter int unsigned          ADDR_W   = 5,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  acc_seq_ctrl_if.master    bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StDecode  = 3'd2;
  localparam logic [2:0] StOperand = 3'd3;
  localparam logic [2:0] StExec    = 3'd4;
  localparam logic [2:0] StHalt    = 3'd5;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [2:0]        op;
  logic [ADDR_W-1:0] operand;
  logic              is_data_op;

  // Operand field is the low ADDR_W bits of IR (ADDR_W must not exceed 8).
  assign op         = ir_q[7:5];
  assign operand    = ir_q[ADDR_W-1:0];
  assign is_data_op = (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StIdle, StHalt: begin
        if (start) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d = bus.mem_rdata;
        pc_d = pc_q + ADDR_W'(1);
        unique case (bus.mem_rdata[7:5])
          OpHlt:                      state_d = StHalt;
          OpAdd, OpAnd, OpXor, OpLda: state_d = StOperand;
          default:                    state_d = StExec;
        endcase
      end
      StOperand: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        if (op == OpSkz && bus.acc_zero) pc_d = pc_q + ADDR_W'(1);
        if (op == OpJmp)                 pc_d = operand;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    bus.mem_addr   = pc_q;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.alu_op     = 3'b000;
    bus.acc_update = 1'b0;
    case (state_q)
      StFetch: bus.mem_rd = 1'b1;
      StOperand: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = operand;
        bus.alu_op   = op;
      end
      StExec: begin
        bus.alu_op     = op;
        bus.acc_update = is_data_op;
        if (op == OpSto) begin
          bus.mem_wr   = 1'b1;
          bus.mem_addr = operand;
        end
      end
      default: ;
    endcase
  end

  assign pc     = pc_q;
  assign busy   = (state_q == StFetch) || (state_q == StDecode) ||
                  (state_q == StOperand) || (state_q == StExec);
  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: directed scenarios plus random programs checked against
// an instruction-level model of the machine.
module tb_acc_seq_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] pc;
  logic       busy;
  logic       halted;

  acc_seq_ctrl_if #(.ADDR_W(5)) bus ();

  acc_seq_ctrl #(.ADDR_W(5), .RESET_PC(5'd0)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted)
  );

  always #5 clock = ~clock;

  // Environment: synchronous memory and ALU + accumulator.
  logic [7:0] mem [32];
  logic [7:0] rdata;
  logic [7:0] acc;
  assign bus.mem_rdata = rdata;
  assign bus.acc_zero  = (acc == 8'h00);

  always @(posedge clock) begin
    if (bus.mem_rd) rdata <= mem[bus.mem_addr];
    if (bus.mem_wr) mem[bus.mem_addr] <= acc;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) acc <= 8'h00;
    else if (bus.acc_update) begin
      case (bus.alu_op)
        3'b010:  acc <= acc + rdata;
        3'b011:  acc <= acc & rdata;
        3'b100:  acc <= acc ^ rdata;
        3'b101:  acc <= rdata;
        default: acc <= acc;
      endcase
    end
  end

  int errors = 0;
  int checks = 0;

  // Instruction-level reference model.
  logic [7:0] model_mem [32];
  logic [7:0] model_acc;
  logic [4:0] model_pc;
  logic       model_halted;
  int         model_cycles;

  task automatic model_run(input int max_ins);
    logic [7:0] ins;
    logic [4:0] a;
    model_mem    = mem;
    model_acc    = 8'h00;
    model_pc     = 5'd0;
    model_halted = 1'b0;
    model_cycles = 0;
    for (int n = 0; n < max_ins && !model_halted; n++) begin
      ins      = model_mem[model_pc];
      a        = ins[4:0];
      model_pc = model_pc + 5'd1;
      case (ins[7:5])
        3'd0: begin model_halted = 1'b1; model_cycles += 2; end
        3'd1: begin if (model_acc == 8'h00) model_pc = model_pc + 5'd1; model_cycles += 3; end
        3'd2: begin model_acc = model_acc + model_mem[a]; model_cycles += 4; end
        3'd3: begin model_acc = model_acc & model_mem[a]; model_cycles += 4; end
        3'd4: begin model_acc = model_acc ^ model_mem[a]; model_cycles += 4; end
        3'd5: begin model_acc = model_mem[a]; model_cycles += 4; end
        3'd6: begin model_mem[a] = model_acc; model_cycles += 3; end
        default: begin model_pc = a; model_cycles += 3; end
      endcase
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the edge that samples start.
  task automatic kick();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = 8'hA5; mem[1] = 8'h46; mem[2] = 8'hC7; mem[3] = 8'h00;
    mem[5] = 8'h12; mem[6] = 8'h30;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || pc !== 5'd0 || bus.mem_addr !== 5'd0 ||
        bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || bus.acc_update !== 1'b0 ||
        bus.alu_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b halted=%b pc=%h addr=%h rd=%b wr=%b upd=%b op=%h required all 0",
               busy, halted, pc, bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.acc_update, bus.alu_op);
    end
    clear_mem();
    mem[0] = 8'h45; mem[5] = 8'h12;
    do_reset();
    kick();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.acc_update !== 1'b1 || bus.alu_op !== 3'd2) begin
      errors++;
      $display("FAIL reset_exec_add: upd=%b op=%h required upd=1 op=2", bus.acc_update, bus.alu_op);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || pc !== 5'd0 || bus.mem_addr !== 5'd0 ||
        bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || bus.acc_update !== 1'b0 ||
        bus.alu_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_add: busy=%b halted=%b pc=%h addr=%h rd=%b wr=%b upd=%b op=%h required all 0",
               busy, halted, pc, bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.acc_update, bus.alu_op);
    end
    // A store aborted by reset must not reach memory.
    clear_mem();
    mem[0] = 8'hC7; mem[7] = 8'h55;
    do_reset();
    kick();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.mem_wr !== 1'b1) begin
      errors++;
      $display("FAIL reset_exec_sto: mem_wr=%b required 1", bus.mem_wr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sto_wr: mem_wr=%b required 0", bus.mem_wr);
    end
    @(posedge clock); #1;
    checks++;
    if (mem[7] !== 8'h55) begin
      errors++;
      $display("FAIL reset_no_write: mem[7]=%h required 55", mem[7]);
    end
    reset = 1'b0;
  endtask

  task automatic test_lda_add_sto_hlt(input bit hold_start);
    int n;
    load_basic();
    do_reset();
    start = 1'b1;
    @(posedge clock); #1;
    if (!hold_start) start = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL first_fetch: rd=%b addr=%h required rd=1 addr=0", bus.mem_rd, bus.mem_addr);
    end
    n = 0;
    while (!halted && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (n == 9) start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (n !== 13 || mem[7] !== 8'h42 || pc !== 5'd4 || acc !== 8'h42) begin
      errors++;
      $display("FAIL basic_prog(hold=%0d): cycles=%0d mem7=%h pc=%h acc=%h required 13 42 04 42",
               hold_start, n, mem[7], pc, acc);
    end
  endtask

  task automatic test_skz();
    clear_mem();
    mem[0] = 8'hAA; mem[1] = 8'h20; mem[2] = 8'hFF; mem[3] = 8'h00; mem[10] = 8'h00;
    do_reset();
    kick();
    repeat (7) @(posedge clock);
    #1;
    checks++;
    if (pc !== 5'd3 || bus.mem_addr !== 5'd3 || bus.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL skz_taken: pc=%h addr=%h rd=%b required pc=3 addr=3 rd=1", pc, bus.mem_addr, bus.mem_rd);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (halted !== 1'b1 || pc !== 5'd4) begin
      errors++;
      $display("FAIL skz_taken_halt: halted=%b pc=%h required 1 04", halted, pc);
    end
    mem[10] = 8'h01;
    do_reset();
    kick();
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (pc !== 5'h1F || bus.mem_addr !== 5'h1F || bus.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL skz_not_taken: pc=%h addr=%h rd=%b required pc=1f addr=1f rd=1",
               pc, bus.mem_addr, bus.mem_rd);
    end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0] = 8'hFF; mem[31] = 8'hA5; mem[5] = 8'h12;
    do_reset();
    kick();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.mem_addr !== 5'd31 || bus.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL wrap_fetch31: addr=%h rd=%b required 1f 1", bus.mem_addr, bus.mem_rd);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (pc !== 5'd0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h required 00", pc);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.mem_addr !== 5'd0 || bus.mem_rd !== 1'b1 || acc !== 8'h12) begin
      errors++;
      $display("FAIL wrap_next_fetch: addr=%h rd=%b acc=%h required 00 1 12", bus.mem_addr, bus.mem_rd, acc);
    end
  endtask

  task automatic test_resume();
    int n;
    int pulses;
    load_basic();
    mem[4] = 8'h46;
    do_reset();
    kick();
    n = 0;
    while (!halted && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (halted !== 1'b1 || pc !== 5'd4) begin
      errors++;
      $display("FAIL resume_first_halt: halted=%b pc=%h required 1 04", halted, pc);
    end
    kick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd4) begin
      errors++;
      $display("FAIL resume_fetch: rd=%b addr=%h required 1 04", bus.mem_rd, bus.mem_addr);
    end
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      if (bus.acc_update) pulses++;
      if (k == 3) begin
        checks++;
        if (bus.acc_update !== 1'b1) begin
          errors++;
          $display("FAIL resume_update_time: acc_update=%b required 1", bus.acc_update);
        end
      end
    end
    checks++;
    if (pulses !== 1 || acc !== 8'h72 || halted !== 1'b1 || pc !== 5'd6) begin
      errors++;
      $display("FAIL resume_end: pulses=%0d acc=%h halted=%b pc=%h required 1 72 1 06",
               pulses, acc, halted, pc);
    end
  endtask

  task automatic test_random(input int iters);
    int mem_bad;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      model_run(12);
      do_reset();
      kick();
      repeat (model_cycles) begin
        @(posedge clock); #1;
        checks++;
        if (bus.mem_rd && bus.mem_wr) begin
          errors++;
          $display("FAIL rand_rd_wr_overlap: iter=%0d rd=1 wr=1 required not both", it);
        end
      end
      checks++;
      if (pc !== model_pc || acc !== model_acc || halted !== model_halted ||
          busy !== !model_halted) begin
        errors++;
        $display("FAIL rand_state iter=%0d: pc=%h acc=%h halted=%b busy=%b required %h %h %b %b",
                 it, pc, acc, halted, busy, model_pc, model_acc, model_halted, !model_halted);
      end
      mem_bad = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== model_mem[i]) mem_bad++;
      checks++;
      if (mem_bad != 0) begin
        errors++;
        $display("FAIL rand_mem iter=%0d: %0d words differ required 0", it, mem_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda_add_sto_hlt(1'b0);
    test_lda_add_sto_hlt(1'b1);
    test_skz();
    test_pc_wrap();
    test_resume();
    test_random(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
